bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-master arbiter that multiplexes an instruction-fetch port and a
//   load/store port onto one shared single-port memory bus. Load/store wins
//   ties because it belongs to the older instruction in the pipeline.
//
//   Compile-time option: define ARB_TIMEOUT_EN to abort a granted transfer
//   after TIMEOUT_CYCLES cycles without bus_ack_i. The abort returns an ack
//   with zero data to the requester and raises bus_err_o for one cycle.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-low reset
//   if_*            fetch requester    : req/addr in, ack/data out
//   mem_*           load/store requester: req/we/addr/sel/wdata in, ack/rdata out
//   bus_*_o         registered shared-bus request (held for the whole transfer)
//   bus_rdata_i/ack_i  shared-bus response
//   stallreq_*_o    pipeline stall while a request is outstanding
//   bus_err_o       one-cycle timeout pulse (always 0 without ARB_TIMEOUT_EN)
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, IF_XFER, MEM_XFER} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_cmd_t;

  state_t   state_q, state_d;
  bus_cmd_t cmd_q, cmd_d;
  logic     req_q, req_d;
  logic     in_xfer, timeout, done;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_xfer = (state_q != IDLE);

  // Expiry fires on the TIMEOUT_CYCLES-th waiting cycle; an ack in that same
  // cycle takes precedence and completes normally.
`ifdef ARB_TIMEOUT_EN
  assign timeout = in_xfer && !bus_ack_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done = in_xfer && (bus_ack_i || timeout);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    req_d   = req_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d = MEM_XFER;
          cmd_d   = '{we: mem_we_i, addr: mem_addr_i, sel: mem_sel_i, wdata: mem_wdata_i};
          req_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (if_req_i) begin
          state_d = IF_XFER;
          cmd_d   = '{we: 1'b0, addr: if_addr_i, sel: 4'hF, wdata: 32'h0};
          req_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      IF_XFER, MEM_XFER: begin
        if (done) begin
          state_d = IDLE;
          cmd_d   = '0;
          req_d   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Response side is combinational; gating with rst keeps a response that
  // races a reset from ever reaching a requester.
  always_comb begin
    if_ack_o    = rst && done && (state_q == IF_XFER);
    mem_ack_o   = rst && done && (state_q == MEM_XFER);
    if_data_o   = (if_ack_o  && bus_ack_i) ? bus_rdata_i : 32'h0;
    mem_rdata_o = (mem_ack_o && bus_ack_i) ? bus_rdata_i : 32'h0;
    bus_err_o   = rst && timeout;
  end

  assign stallreq_if_o  = rst && if_req_i  && !if_ack_o;
  assign stallreq_mem_o = rst && mem_req_i && !mem_ack_o;

  assign bus_req_o   = req_q;
  assign bus_we_o    = cmd_q.we;
  assign bus_addr_o  = cmd_q.addr;
  assign bus_sel_o   = cmd_q.sel;
  assign bus_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [3:0]  mem_sel_i;
  logic        mem_ack_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic        stallreq_if_o, stallreq_mem_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = 0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_sel_i = 0; mem_wdata_i = 0;
    bus_rdata_i = 0; bus_ack_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0; if_req_i = 1; mem_req_i = 1; bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
    tick(); tick();
    @(negedge clk);
    checks++; if ({if_ack_o, mem_ack_o, bus_err_o} !== 3'b000) begin errors++; $display("FAIL reset_acks got=%b exp=000", {if_ack_o, mem_ack_o, bus_err_o}); end
    checks++; if ({stallreq_if_o, stallreq_mem_o} !== 2'b00) begin errors++; $display("FAIL reset_stall got=%b exp=00", {stallreq_if_o, stallreq_mem_o}); end
    checks++; if ({if_data_o, mem_rdata_o} !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {if_data_o, mem_rdata_o}); end
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== 70'h0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}); end
    tick();
    clear_inputs(); rst = 1;
    tick();
  endtask

  task automatic test_if_fetch();
    int pulses;
    pulses = 0;
    if_req_i = 1; if_addr_i = 32'h100;
    @(negedge clk);
    checks++; if ({stallreq_if_o, bus_req_o} !== 2'b10) begin errors++; $display("FAIL if_pre_grant got=%b exp=10", {stallreq_if_o, bus_req_o}); end
    tick();
    @(negedge clk);
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {1'b1, 1'b0, 32'h100, 4'hF, 32'h0}) begin
      errors++; $display("FAIL if_bus_cmd got=%b/%b/%h/%h/%h exp=1/0/100/f/0", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 1) begin bus_ack_i = 1; bus_rdata_i = 32'h3C01_0001; end
      else begin bus_ack_i = 0; if (c == 2) if_req_i = 0; end
      @(negedge clk);
      if (if_ack_o) pulses++;
      if (c == 0) begin
        checks++; if ({stallreq_if_o, if_ack_o} !== 2'b10) begin errors++; $display("FAIL if_wait got=%b exp=10", {stallreq_if_o, if_ack_o}); end
      end
      if (c == 1) begin
        checks++; if ({if_ack_o, stallreq_if_o, if_data_o} !== {2'b10, 32'h3C01_0001}) begin
          errors++; $display("FAIL if_ack got=%b%b data=%h exp=10 data=3c010001", if_ack_o, stallreq_if_o, if_data_o); end
      end
      if (c == 2) begin
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL if_release got=%b exp=0", bus_req_o); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL if_ack_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_priority_hold();
    if_req_i = 1; if_addr_i = 32'h400;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h200; mem_sel_i = 4'b0011; mem_wdata_i = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {2'b11, 32'h200, 4'b0011, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL prio_mem_cmd got=%b/%b/%h/%h/%h exp=1/1/200/3/deadbeef", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o); end
    mem_addr_i = 32'h300;
    tick();
    @(negedge clk);
    checks++; if ({bus_addr_o, if_ack_o, mem_ack_o} !== {32'h200, 2'b00}) begin
      errors++; $display("FAIL hold_addr got=%h acks=%b%b exp=200 acks=00", bus_addr_o, if_ack_o, mem_ack_o); end
    tick();
    bus_ack_i = 1; bus_rdata_i = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({mem_ack_o, if_ack_o, if_data_o, bus_addr_o} !== {2'b10, 32'h0, 32'h200}) begin
      errors++; $display("FAIL prio_mem_ack got=%b%b ifdata=%h addr=%h exp=10 0 200", mem_ack_o, if_ack_o, if_data_o, bus_addr_o); end
    tick();
    bus_ack_i = 0; mem_req_i = 0;
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b exp=0", bus_req_o); end
    tick();
    @(negedge clk);
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_sel_o} !== {2'b10, 32'h400, 4'hF}) begin
      errors++; $display("FAIL prio_if_next got=%b/%b/%h/%h exp=1/0/400/f", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o); end
    tick(); bus_ack_i = 1;
    tick(); bus_ack_i = 0; if_req_i = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h500; mem_sel_i = 4'hF;
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if ({bus_req_o, mem_ack_o} !== 2'b10) begin errors++; $display("FAIL rstmid_pre got=%b exp=10", {bus_req_o, mem_ack_o}); end
    tick();
    rst = 1; mem_req_i = 0; bus_ack_i = 1; bus_rdata_i = 32'hCAFE_F00D;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({bus_req_o, mem_ack_o, if_ack_o, mem_rdata_o} !== {3'b000, 32'h0}) begin
        errors++; $display("FAIL rstmid_ignore%0d got=%b%b%b data=%h exp=000 data=0", c, bus_req_o, mem_ack_o, if_ack_o, mem_rdata_o); end
      tick();
    end
    bus_ack_i = 0;
  endtask

  task automatic test_timeout();
    int ack_cyc, acks, errs;
    ack_cyc = -1; acks = 0; errs = 0;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h600; mem_sel_i = 4'hF; bus_rdata_i = 32'hFFFF_FFFF;
    tick();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus_err_o) errs++;
      if (mem_ack_o) begin
        acks++; ack_cyc = c;
        checks++; if ({bus_err_o, mem_rdata_o} !== {1'b1, 32'h0}) begin
          errors++; $display("FAIL timeout_resp err=%b data=%h exp err=1 data=0", bus_err_o, mem_rdata_o); end
      end
      tick();
      if (acks != 0) mem_req_i = 0;
    end
`ifdef ARB_TIMEOUT_EN
    checks++; if (ack_cyc != T || acks != 1 || errs != 1) begin
      errors++; $display("FAIL timeout_pulse cyc=%0d acks=%0d errs=%0d exp cyc=%0d acks=1 errs=1", ack_cyc, acks, errs, T); end
    @(negedge clk);
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL timeout_drop got=%b exp=0", bus_req_o); end
`else
    @(negedge clk);
    checks++; if (acks != 0 || errs != 0 || bus_req_o !== 1'b1) begin
      errors++; $display("FAIL no_timeout acks=%0d errs=%0d req=%b exp 0 0 1", acks, errs, bus_req_o); end
    tick(); bus_ack_i = 1;
    tick(); bus_ack_i = 0; mem_req_i = 0;
    tick();
`endif
  endtask

  // Transaction-level reference: one owner at a time, mem preferred on ties,
  // owner's command captured at grant, released on ack (or on the T-th idle wait).
  task automatic test_random();
    int owner, wait_n;
    logic        e_req, e_we, x_if_ack, x_mem_ack, x_err, to;
    logic [31:0] e_addr, e_wdata, x_if_data, x_mem_data;
    logic [3:0]  e_sel;
    owner = 0; wait_n = 0; e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_sel = 0;
    x_if_ack = 0; x_mem_ack = 0;
    clear_inputs(); rst = 0; tick(); rst = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (owner != 0) begin
        if (x_if_ack || x_mem_ack) begin owner = 0; e_req = 0; end
        else wait_n++;
      end else if (mem_req_i) begin
        owner = 2; e_req = 1; wait_n = 0;
        e_we = mem_we_i; e_addr = mem_addr_i; e_sel = mem_sel_i; e_wdata = mem_wdata_i;
      end else if (if_req_i) begin
        owner = 1; e_req = 1; wait_n = 0;
        e_we = 0; e_addr = if_addr_i; e_sel = 4'hF; e_wdata = 0;
      end
      #1;
      if (!if_req_i || x_if_ack) begin if_req_i = 1'($urandom_range(0, 1)); if_addr_i = $urandom; end
      if (!mem_req_i || x_mem_ack) begin
        mem_req_i = 1'($urandom_range(0, 1)); mem_we_i = 1'($urandom_range(0, 1));
        mem_addr_i = $urandom; mem_sel_i = 4'($urandom); mem_wdata_i = $urandom;
      end else if ($urandom_range(0, 3) == 0) begin
        mem_addr_i = $urandom; mem_wdata_i = $urandom; mem_sel_i = 4'($urandom);
      end
      bus_ack_i = ($urandom_range(0, 2) == 0); bus_rdata_i = $urandom;
      @(negedge clk);
`ifdef ARB_TIMEOUT_EN
      to = (owner != 0) && !bus_ack_i && (wait_n == T - 1);
`else
      to = 1'b0;
`endif
      x_if_ack   = (owner == 1) && (bus_ack_i || to);
      x_mem_ack  = (owner == 2) && (bus_ack_i || to);
      x_err      = to;
      x_if_data  = ((owner == 1) && bus_ack_i) ? bus_rdata_i : 32'h0;
      x_mem_data = ((owner == 2) && bus_ack_i) ? bus_rdata_i : 32'h0;
      checks++; if ({if_ack_o, mem_ack_o, bus_err_o, bus_req_o} !== {x_if_ack, x_mem_ack, x_err, e_req}) begin
        errors++; $display("FAIL rand_ctl cyc=%0d got=%b%b%b%b exp=%b%b%b%b", cyc, if_ack_o, mem_ack_o, bus_err_o, bus_req_o, x_if_ack, x_mem_ack, x_err, e_req); end
      checks++; if ({if_data_o, mem_rdata_o} !== {x_if_data, x_mem_data}) begin
        errors++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc, if_data_o, mem_rdata_o, x_if_data, x_mem_data); end
      checks++; if ({stallreq_if_o, stallreq_mem_o} !== {if_req_i & ~x_if_ack, mem_req_i & ~x_mem_ack}) begin
        errors++; $display("FAIL rand_stall cyc=%0d got=%b%b exp=%b%b", cyc, stallreq_if_o, stallreq_mem_o, if_req_i & ~x_if_ack, mem_req_i & ~x_mem_ack); end
      if (e_req) begin
        checks++; if ({bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o} !== {e_we, e_addr, e_sel, e_wdata}) begin
          errors++; $display("FAIL rand_cmd cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", cyc, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, e_we, e_addr, e_sel, e_wdata); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_if_fetch();
    test_priority_hold();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
